// File: rtl/flag_pwm_pkg.sv
// Shared definitions for the flag-driven PWM blocks.
//   breath_state_e : 2-bit breathing FSM encoding (UP=0, DOWN=1, HOLD_HI=2, HOLD_LO=3)
//   clog2_w()      : bits needed to hold values 0..value-1 (minimum 1); shared with the divider
package flag_pwm_pkg;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DOWN    = 2'd1,
        ST_HOLD_HI = 2'd2,
        ST_HOLD_LO = 2'd3
    } breath_state_e;

    // ceil(log2(value)), never less than 1 so a counter always has a bit
    function automatic int unsigned clog2_w(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pwm_tick_counter.sv
// PWM period tick counter.
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   tick       in   count enable (one step per high cycle)
//   tick_cnt   out  position inside the PWM period, 0..PERIOD-1 (registered)
//   wrap_c     out  combinational: this tick ends the period
//   period_end out  registered one-cycle pulse following each wrap
module pwm_tick_counter
    import flag_pwm_pkg::*;
#(
    parameter int unsigned PERIOD = 16,
    localparam int unsigned CNT_W = clog2_w(PERIOD)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             wrap_c,
    output logic             period_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    assign wrap_c = tick && (tick_cnt == CNT_LAST);

    // Period position and end-of-period pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt   <= '0;
            period_end <= 1'b0;
        end else begin
            period_end <= wrap_c;
            if (tick) begin
                tick_cnt <= wrap_c ? '0 : tick_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/flag_breathing_pwm.sv
// Breathing PWM driven by the divider's one-cycle flag pulse.
// Duty ramps 0 -> PERIOD -> 0, one step per completed PWM period.
// Optional macro BREATH_HOLD_EN: dwell HOLD_PERIODS periods at peak and trough.
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   cnt_flag   in   tick enable from the flag divider
//   run_en     in   1 = run; 0 = freeze all state and force pwm_out low
//   pwm_out    out  registered PWM output
//   duty       out  current duty, 0..PERIOD
//   dir_down   out  1 while ramping down or holding high
//   period_end out  one-cycle pulse per completed PWM period
module flag_breathing_pwm
    import flag_pwm_pkg::*;
#(
    parameter int unsigned PERIOD       = 16,
    parameter int unsigned HOLD_PERIODS = 4,
    localparam int unsigned DUTY_W = clog2_w(PERIOD + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cnt_flag,
    input  logic              run_en,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic              dir_down,
    output logic              period_end
);

    localparam int unsigned       CNT_W    = clog2_w(PERIOD);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);

    // Elaboration-time parameter sanity
    if (PERIOD < 2) begin : g_bad_period
        $error("flag_breathing_pwm: PERIOD must be >= 2");
    end
    if (HOLD_PERIODS < 1) begin : g_bad_hold
        $error("flag_breathing_pwm: HOLD_PERIODS must be >= 1");
    end

    logic             tick_c;
    logic             wrap_c;
    logic [CNT_W-1:0] tick_cnt;

    breath_state_e     state_q;
    breath_state_e     state_d;
    logic [DUTY_W-1:0] duty_d;
    logic              pwm_d;
    logic              dir_down_d;

`ifdef BREATH_HOLD_EN
    localparam int unsigned       HOLD_W    = clog2_w(HOLD_PERIODS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
`endif

    // run_en gates the tick, which freezes the counter, FSM and duty together
    assign tick_c = cnt_flag & run_en;

    pwm_tick_counter #(
        .PERIOD (PERIOD)
    ) u_tick_counter (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tick       (tick_c),
        .tick_cnt   (tick_cnt),
        .wrap_c     (wrap_c),
        .period_end (period_end)
    );

    // State, duty and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_UP;
            duty       <= '0;
            pwm_out    <= 1'b0;
            dir_down   <= 1'b0;
`ifdef BREATH_HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            duty       <= duty_d;
            pwm_out    <= pwm_d;
            dir_down   <= dir_down_d;
`ifdef BREATH_HOLD_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // Breathing FSM: steps only on a period wrap so each period sees one duty
    always_comb begin
        state_d    = state_q;
        duty_d     = duty;
`ifdef BREATH_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif

        if (wrap_c) begin
            case (state_q)
                ST_UP: begin
                    if (duty < DUTY_TOP) begin
                        duty_d = duty + DUTY_ONE;
                    end else begin
                        duty_d = DUTY_MAX;
`ifdef BREATH_HOLD_EN
                        state_d    = ST_HOLD_HI;
                        hold_cnt_d = '0;
`else
                        state_d = ST_DOWN;
`endif
                    end
                end
                ST_DOWN: begin
                    if (duty > DUTY_ONE) begin
                        duty_d = duty - DUTY_ONE;
                    end else begin
                        duty_d = '0;
`ifdef BREATH_HOLD_EN
                        state_d    = ST_HOLD_LO;
                        hold_cnt_d = '0;
`else
                        state_d = ST_UP;
`endif
                    end
                end
`ifdef BREATH_HOLD_EN
                ST_HOLD_HI: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_DOWN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_UP;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_UP;
                end
            endcase
        end

        // Compare uses the pre-edge count and duty: one clock of latency
        pwm_d      = run_en && (DUTY_W'(tick_cnt) < duty);
        dir_down_d = (state_d == ST_DOWN) || (state_d == ST_HOLD_HI);
    end

endmodule
